// File: rtl/voice_alloc.sv
// rtl/voice_alloc.sv - polyphonic voice allocator with a slot-scan FSM
// Each accepted event scans every slot, then retriggers, fills a free slot, or steals the oldest voice.
module voice_alloc #(
  parameter int N_VOICES = 8,
  parameter int IW       = $clog2(N_VOICES),
  parameter int AGE_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ev_valid_i,
  output logic                    ev_ready_o,
  input  logic                    ev_on_i,
  input  logic [7:0]              ev_note_i,
  input  logic                    all_off_i,
  output logic [8*N_VOICES-1:0]   voice_notes_o,
  output logic [N_VOICES-1:0]     voice_active_o,
  output logic                    steal_o
);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  state_t               state;
  logic [7:0]           note [N_VOICES];
  logic [AGE_W-1:0]     age  [N_VOICES];
  logic [N_VOICES-1:0]  active;
  logic [IW-1:0]        idx;

  logic                 ev_on_q;
  logic [7:0]           ev_note_q;
  logic                 match_found, free_found, oldest_found;
  logic [IW-1:0]        match_idx, free_idx, oldest_idx;
  logic [AGE_W-1:0]     oldest_age;

  logic                 tgt_valid;
  logic                 do_steal;
  logic [IW-1:0]        tgt;

  // Target slot for a note-on: retrigger beats free slot beats steal.
  always_comb begin
    tgt_valid = 1'b0;
    do_steal  = 1'b0;
    tgt       = '0;
    if (ev_on_q && ev_note_q != 8'd0) begin
      if (match_found) begin
        tgt       = match_idx;
        tgt_valid = 1'b1;
      end else if (free_found) begin
        tgt       = free_idx;
        tgt_valid = 1'b1;
      end else if (oldest_found) begin
        tgt       = oldest_idx;
        tgt_valid = 1'b1;
        do_steal  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    steal_o <= 1'b0;
    if (!rst_n || all_off_i) begin
      state        <= IDLE;
      idx          <= '0;
      active       <= '0;
      ev_on_q      <= 1'b0;
      ev_note_q    <= 8'd0;
      match_found  <= 1'b0;
      free_found   <= 1'b0;
      oldest_found <= 1'b0;
      match_idx    <= '0;
      free_idx     <= '0;
      oldest_idx   <= '0;
      oldest_age   <= '0;
      for (int i = 0; i < N_VOICES; i++) begin
        note[i] <= 8'd0;
        age[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (ev_valid_i) begin
            ev_on_q      <= ev_on_i;
            ev_note_q    <= ev_note_i;
            match_found  <= 1'b0;
            free_found   <= 1'b0;
            oldest_found <= 1'b0;
            match_idx    <= '0;
            free_idx     <= '0;
            oldest_idx   <= '0;
            oldest_age   <= '0;
            idx          <= '0;
            state        <= SCAN;
          end
        end
        SCAN: begin
          if (active[idx] && note[idx] == ev_note_q && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= idx;
          end
          if (!active[idx] && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          // Strict compare keeps the lowest index on equal ages.
          if (active[idx] && (!oldest_found || age[idx] > oldest_age)) begin
            oldest_found <= 1'b1;
            oldest_idx   <= idx;
            oldest_age   <= age[idx];
          end
          if (idx == IW'(N_VOICES - 1)) begin
            state <= COMMIT;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        COMMIT: begin
          if (tgt_valid) begin
            for (int i = 0; i < N_VOICES; i++) begin
              if (IW'(i) == tgt) begin
                age[i] <= '0;
              end else if (active[i] && age[i] != AGE_MAX) begin
                age[i] <= age[i] + AGE_W'(1);
              end
            end
            if (!match_found) begin
              note[tgt]   <= ev_note_q;
              active[tgt] <= 1'b1;
            end
            steal_o <= do_steal;
          end else if (!ev_on_q && ev_note_q != 8'd0 && match_found) begin
            note[match_idx]   <= 8'd0;
            active[match_idx] <= 1'b0;
            age[match_idx]    <= '0;
          end
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ev_ready_o     = (state == IDLE);
  assign voice_active_o = active;

  always_comb begin
    voice_notes_o = '0;
    for (int i = 0; i < N_VOICES; i++) begin
      voice_notes_o[8*i +: 8] = note[i];
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// tb/tb_voice_alloc.sv - self-checking bench for voice_alloc with N_VOICES = 4
// An event-level allocator model is compared against the outputs every cycle.
module tb_voice_alloc;

  localparam int NV   = 4;
  localparam int AMAX = 255;

  logic        clk;
  logic        rst_n;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_on;
  logic [7:0]  ev_note;
  logic        all_off;
  logic [31:0] voice_notes;
  logic [3:0]  voice_active;
  logic        steal;

  voice_alloc #(.N_VOICES(NV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ev_valid_i     (ev_valid),
    .ev_ready_o     (ev_ready),
    .ev_on_i        (ev_on),
    .ev_note_i      (ev_note),
    .all_off_i      (all_off),
    .voice_notes_o  (voice_notes),
    .voice_active_o (voice_active),
    .steal_o        (steal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int steal_seen  = 0;
  int acc_q[$];
  logic prev_ready = 1'b1;

  // Event-level model: an accepted event takes effect NV+1 edges later.
  int   m_note [NV];
  int   m_age  [NV];
  bit   m_active [NV];
  bit   m_busy   = 1'b0;
  int   m_cnt    = 0;
  bit   m_steal  = 1'b0;
  bit   m_ev_on  = 1'b0;
  int   m_ev_note = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic m_apply();
    int tgt;
    tgt = -1;
    if (m_ev_note == 0) return;
    for (int i = 0; i < NV; i++)
      if (tgt < 0 && m_active[i] && m_note[i] == m_ev_note) tgt = i;
    if (m_ev_on) begin
      if (tgt < 0) begin
        for (int i = 0; i < NV; i++)
          if (tgt < 0 && !m_active[i]) tgt = i;
        if (tgt < 0) begin
          tgt = 0;
          for (int i = 1; i < NV; i++)
            if (m_age[i] > m_age[tgt]) tgt = i;
          m_steal = 1'b1;
        end
        m_note[tgt] = m_ev_note;
      end
      for (int i = 0; i < NV; i++)
        if (i != tgt && m_active[i] && m_age[i] < AMAX) m_age[i]++;
      m_active[tgt] = 1'b1;
      m_age[tgt]    = 0;
    end else if (tgt >= 0) begin
      m_note[tgt]   = 0;
      m_active[tgt] = 1'b0;
      m_age[tgt]    = 0;
    end
  endtask

  task automatic m_step();
    m_steal = 1'b0;
    if (!rst_n || all_off) begin
      for (int i = 0; i < NV; i++) begin
        m_note[i] = 0; m_age[i] = 0; m_active[i] = 1'b0;
      end
      m_busy = 1'b0;
      m_cnt  = 0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_apply();
        m_busy = 1'b0;
      end
    end else if (ev_valid) begin
      m_ev_on   = ev_on;
      m_ev_note = ev_note;
      m_busy    = 1'b1;
      m_cnt     = NV + 1;
    end
  endtask

  always @(posedge clk) begin
    logic [31:0] exp_notes;
    logic [3:0]  exp_act;
    m_step();
    #1;
    cyc++;
    for (int i = 0; i < NV; i++) begin
      exp_notes[8*i +: 8] = m_note[i][7:0];
      exp_act[i]          = m_active[i];
    end
    chk("voice_notes", voice_notes, exp_notes);
    chk("voice_active", {28'd0, voice_active}, {28'd0, exp_act});
    chk("ev_ready", {31'd0, ev_ready}, {31'd0, !m_busy});
    chk("steal", {31'd0, steal}, {31'd0, m_steal});
    if (steal === 1'b1) steal_seen++;
    if (prev_ready && ev_ready === 1'b0) acc_q.push_back(cyc);
    prev_ready = ev_ready;
  end

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic send(input logic on, input logic [7:0] n, output int lat);
    int b;
    @(negedge clk);
    ev_on = on; ev_note = n; ev_valid = 1'b1;
    b = 0;
    while (!ev_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (b >= 50) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: ready stuck at %0b expected 1", ev_ready);
    end
    @(negedge clk);
    ev_valid = 1'b0;
    lat = 0;
    while (!ev_ready && lat < 50) begin
      lat++;
      @(negedge clk);
    end
  endtask

  logic       tbl_on   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0] tbl_note [6] = '{8'd50, 8'd0, 8'd51, 8'd50, 8'd52, 8'd0};

  initial begin
    int lat;
    int base;
    int j;
    rst_n = 1'b0; ev_valid = 1'b0; ev_on = 1'b0; ev_note = 8'd0; all_off = 1'b0;

    // Reset, then fill three slots
    do_reset();
    chk("reset_notes", voice_notes, 32'h0);
    chk("reset_active", {28'd0, voice_active}, 32'h0);
    chk("reset_ready", {31'd0, ev_ready}, 32'h1);
    chk("reset_steal", {31'd0, steal}, 32'h0);
    send(1'b1, 8'd60, lat); chk("lat_60", lat, 5);
    send(1'b1, 8'd64, lat); chk("lat_64", lat, 5);
    send(1'b1, 8'd67, lat); chk("lat_67", lat, 5);
    chk("fill_notes", voice_notes, 32'h0043403C);
    chk("fill_active", {28'd0, voice_active}, 32'h7);

    // Steal oldest
    do_reset();
    base = steal_seen;
    send(1'b1, 8'd60, lat);
    send(1'b1, 8'd62, lat);
    send(1'b1, 8'd64, lat);
    send(1'b1, 8'd65, lat);
    send(1'b1, 8'd69, lat);
    chk("steal_notes", voice_notes, 32'h41403E45);
    chk("steal_count", steal_seen - base, 1);
    chk("model_ages", {m_age[3][7:0], m_age[2][7:0], m_age[1][7:0], m_age[0][7:0]}, 32'h01020300);

    // Retrigger then steal
    do_reset();
    send(1'b1, 8'd60, lat);
    send(1'b1, 8'd62, lat);
    send(1'b1, 8'd60, lat);
    chk("retrig_notes", voice_notes, 32'h00003E3C);
    chk("retrig_active", {28'd0, voice_active}, 32'h3);
    send(1'b1, 8'd64, lat);
    send(1'b1, 8'd65, lat);
    send(1'b1, 8'd70, lat);
    chk("retrig_steal_notes", voice_notes, 32'h4140463C);

    // Note-off handling
    do_reset();
    send(1'b1, 8'd60, lat);
    send(1'b1, 8'd62, lat);
    send(1'b1, 8'd64, lat);
    send(1'b1, 8'd65, lat);
    send(1'b0, 8'd62, lat);
    chk("off62_active", {28'd0, voice_active}, 32'hD);
    chk("off62_notes", voice_notes, 32'h4140003C);
    send(1'b0, 8'd99, lat);
    chk("off99_notes", voice_notes, 32'h4140003C);
    send(1'b1, 8'd71, lat);
    chk("refill_notes", voice_notes, 32'h4140473C);
    chk("refill_active", {28'd0, voice_active}, 32'hF);

    // Panic two cycles into a scan
    base = steal_seen;
    @(negedge clk); ev_on = 1'b1; ev_note = 8'd72; ev_valid = 1'b1;
    @(negedge clk); ev_valid = 1'b0;
    @(negedge clk); all_off = 1'b1;
    @(negedge clk); all_off = 1'b0;
    chk("panic_notes", voice_notes, 32'h0);
    chk("panic_active", {28'd0, voice_active}, 32'h0);
    chk("panic_ready", {31'd0, ev_ready}, 32'h1);
    repeat (8) @(negedge clk);
    chk("panic_no_steal", steal_seen - base, 0);
    chk("panic_no_commit", voice_notes, 32'h0);

    // Panic and valid together while idle: event dropped
    ev_on = 1'b1; ev_note = 8'd73; ev_valid = 1'b1; all_off = 1'b1;
    @(negedge clk); ev_valid = 1'b0; all_off = 1'b0;
    chk("panic_valid_ready", {31'd0, ev_ready}, 32'h1);
    repeat (8) @(negedge clk);
    chk("panic_valid_notes", voice_notes, 32'h0);

    // Continuous valid, next event presented whenever ready
    acc_q.delete();
    j = 0;
    ev_valid = 1'b1;
    for (int c = 0; c < 60 && j < 6; c++) begin
      if (ev_ready) begin
        ev_on = tbl_on[j]; ev_note = tbl_note[j];
        j++;
      end
      @(negedge clk);
    end
    ev_valid = 1'b0;
    send(1'b0, 8'd0, lat);
    chk("hs_accepts", acc_q.size(), 7);
    for (int k = 1; k < 6 && k < acc_q.size(); k++)
      chk("hs_interval", acc_q[k] - acc_q[k-1], 6);
    chk("hs_notes", voice_notes, 32'h00003334);
    chk("hs_active", {28'd0, voice_active}, 32'h3);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
